// File: rtl/uart_hex_dump_tx.sv
// uart_hex_dump_tx: sends each accepted 32-bit word as 8 uppercase ASCII hex chars over 8N1 UART, MS nibble first.
// Define HEX_TX_CRLF_EN to append CR (8'h0D) and LF (8'h0A) after every word.
module uart_hex_dump_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] word_data,
    input  logic        word_valid,
    output logic        word_ready,
    output logic        tx,
    output logic        busy,
    output logic [3:0]  char_idx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
`ifdef HEX_TX_CRLF_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q;
    logic [31:0]   shift_q;
    logic [3:0]    char_q;
    logic          tx_q, busy_q, ready_q;
    logic          wrap;
    logic [7:0]    hex_char, cur_char;

    always_comb begin
        wrap     = baud_q == BAUD_MAX;
        baud_d   = wrap ? '0 : baud_q + 1'b1;
        hex_char = (shift_q[31:28] > 4'd9) ? {4'h0, shift_q[31:28]} + 8'h37
                                           : {4'h0, shift_q[31:28]} + 8'h30;
`ifdef HEX_TX_CRLF_EN
        cur_char = (char_q == 4'd8) ? 8'h0D : (char_q == 4'd9) ? 8'h0A : hex_char;
`else
        cur_char = hex_char;
`endif
    end

    // The current nibble always sits in shift_q[31:28]; it shifts once per finished character.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            char_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (word_valid) begin
                    state_q <= START;
                    shift_q <= word_data;
                    baud_q  <= '0;
                    bit_q   <= '0;
                    char_q  <= '0;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                end
                START: begin
                    baud_q <= baud_d;
                    if (wrap) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= cur_char[0];
                    end
                end
                DATA: begin
                    baud_q <= baud_d;
                    if (wrap) begin
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= cur_char[bit_q + 3'd1];
                        end
                    end
                end
                STOP: begin
                    baud_q <= baud_d;
                    if (wrap) begin
                        if (char_q == LAST_IDX) begin
                            state_q <= IDLE;
                            char_q  <= '0;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= START;
                            char_q  <= char_q + 4'd1;
                            shift_q <= {shift_q[27:0], 4'h0};
                            tx_q    <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign word_ready = ready_q;
    assign char_idx   = char_q;
endmodule

// File: tb/tb_uart_hex_dump_tx.sv
// tb_uart_hex_dump_tx: checks the serial line cycle by cycle against a frame model built from the word's hex text.
module tb_uart_hex_dump_tx;
    localparam int C = 4;
`ifdef HEX_TX_CRLF_EN
    localparam int N = 10;
`else
    localparam int N = 8;
`endif
    localparam int F = 10 * C;
    localparam int L = N * F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready, tx, busy;
    logic [3:0]  char_idx;

    int    n_cmp = 0;
    int    n_bad = 0;
    string hexs  = "0123456789ABCDEF";

    uart_hex_dump_tx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .tx(tx), .busy(busy), .char_idx(char_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_char(input logic [31:0] w, input int i);
        if (i == 8) return 8'h0D;
        if (i == 9) return 8'h0A;
        return hexs[w[31-4*i -: 4]];
    endfunction

    function automatic logic exp_bit(input logic [31:0] w, input int k);
        logic [7:0] ch;
        int p;
        ch = exp_char(w, k / F);
        p  = (k % F) / C;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return ch[p-1];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns at the idle cycle after the word.
    task automatic xmit(input logic [31:0] w, input bit hold, input logic [31:0] nxt, input bit poke);
        logic [7:0] rx = '0;
        int p;
        word_data  = w;
        word_valid = 1'b1;
        chk("ready_before", 32'(word_ready), 1);
        chk("tx_before", 32'(tx), 1);
        @(negedge clk);
        word_valid = hold;
        if (hold) word_data = nxt;
        for (int k = 0; k < L; k++) begin
            p = (k % F) / C;
            chk($sformatf("tx_k%0d", k), 32'(tx), 32'(exp_bit(w, k)));
            chk("busy_on", 32'(busy), 1);
            chk("ready_off", 32'(word_ready), 0);
            chk("char_idx", 32'(char_idx), k / F);
            if (k % C == C / 2 && p >= 1 && p <= 8) rx[p-1] = tx;
            if (k % C == C / 2 && p == 8) chk($sformatf("rx_byte%0d", k / F), 32'(rx), 32'(exp_char(w, k / F)));
            if (poke && k == 37) begin
                word_valid = 1'b1;
                word_data  = $urandom;
            end
            if (poke && k == 38) word_valid = 1'b0;
            @(negedge clk);
        end
        chk("tx_idle_after", 32'(tx), 1);
        chk("busy_after", 32'(busy), 0);
        chk("ready_after", 32'(word_ready), 1);
    endtask

    initial begin
        rst_n      = 1'b1;
        word_valid = 1'b0;
        word_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(word_ready), 1);
        chk("rst_char", 32'(char_idx), 0);
        rst_n = 1'b0;
        for (int i = 0; i < 100; i++) begin
            chk("idle_tx", 32'(tx), 1);
            chk("idle_busy", 32'(busy), 0);
            @(negedge clk);
        end
        xmit(32'h1234ABCD, 1'b0, 32'h0, 1'b0);
        xmit(32'h00000000, 1'b0, 32'h0, 1'b0);
        xmit(32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
        xmit(32'h9A000000, 1'b0, 32'h0, 1'b0);
        xmit(32'hDEADBEEF, 1'b1, 32'h00000001, 1'b0);
        xmit(32'h00000001, 1'b0, 32'h0, 1'b0);
        xmit($urandom, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) xmit($urandom, 1'b0, 32'h0, 1'b0);
        word_data  = 32'h12305678;
        word_valid = 1'b1;
        @(negedge clk);
        word_valid = 1'b0;
        repeat (3 * F + 3 * C) @(negedge clk);
        chk("mid_char_idx", 32'(char_idx), 3);
        chk("mid_tx", 32'(tx), 0);
        #1 rst_n = 1'b1;
        #1;
        chk("async_tx", 32'(tx), 1);
        chk("async_busy", 32'(busy), 0);
        chk("async_ready", 32'(word_ready), 1);
        chk("async_char", 32'(char_idx), 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        xmit(32'h0000000F, 1'b0, 32'h0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_hex_dump_tx.md
# uart_hex_dump_tx

Transmit-side companion to the UART hex-nibble instruction loader. Accepts 32-bit words over a valid/ready handshake and sends each one on a UART TX line as 8 uppercase ASCII hex characters, most-significant nibble first. This is the same character encoding the loader accepts, so a dumped word can be fed back to the loader unchanged. It contains its own 8N1 serializer and baud counter, and is used to stream register-file or data-memory contents to the host.

## Interface

Parameters:
- CLKS_PER_BIT, default 434: clock cycles per UART bit (50 MHz / 115200). Legal values are ≥ 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-high (asserted when rst_n = 1)
- word_data  input  32  word to transmit
- word_valid  input  1  word_data is valid
- word_ready  output  1  block can accept a word; high only in IDLE
- tx  output  1  UART serial output; idle level 1
- busy  output  1  high from the accept cycle until the last stop bit completes
- char_idx  output  4  index of the character currently on the line (0–7, or 8/9 for CR/LF)

## Operation

- Reset values: state IDLE, tx = 1, busy = 0, word_ready = 1, char_idx = 0, baud counter = 0, bit counter = 0.
- Accept condition: word_valid && word_ready at a rising edge. word_data is latched into a 32-bit shift register at that edge. word_data is ignored at all other times.
- Hex encoding of nibble n: n ≤ 9 maps to 8'h30 + n; n ≥ 10 maps to 8'h41 + (n − 10). Output is uppercase only.
- Character order: char_idx 0 carries bits [31:28], and so on, down to char_idx 7 carrying bits [3:0].
- State machine:
  - IDLE → START on accept.
  - START (tx = 0, lasts CLKS_PER_BIT cycles) → DATA.
  - DATA: 8 bits, LSB first, each lasting CLKS_PER_BIT cycles → STOP.
  - STOP (tx = 1, lasts CLKS_PER_BIT cycles) → START if more characters remain (char_idx increments), otherwise → IDLE.
- Inter-character gap is zero: the next start bit begins the cycle immediately after the previous stop bit's last cycle.
- word_valid held high while busy has no effect. No word is queued.
- Baud counter counts from 0 to CLKS_PER_BIT−1 and wraps. Bit and state advance only on wrap.

## Timing

- Accept at edge E0. tx = 0 from the cycle after E0 (tx is a registered output). busy = 1 and word_ready = 0 from the same cycle.
- Frame length is 10·CLKS_PER_BIT cycles. Total busy time is N·10·CLKS_PER_BIT cycles, where N = 8, or N = 10 with CR/LF enabled.
- word_ready returns to 1 in the cycle after the final stop bit's last cycle.
- Back-to-back: if word_valid is already high at that edge, the next word is accepted there. Only one idle cycle (tx = 1) separates the words.
- Reset mid-frame: tx = 1, busy = 0, word_ready = 1 immediately (asynchronous). The partially sent word is discarded. After reset deasserts, the next word restarts from char_idx 0.

## Configuration

- HEX_TX_CRLF_EN defined: after char_idx 7, two more characters are sent: 8'h0D (char_idx 8) and 8'h0A (char_idx 9). N = 10.
- Undefined: the word ends after char_idx 7. N = 8. char_idx never exceeds 7.

## Test plan

All scenarios use CLKS_PER_BIT = 4.

- Reset idle: assert rst_n = 1, then release → tx = 1, word_ready = 1, busy = 0. tx stays 1 for 100 cycles with word_valid = 0.
- Single word 32'h1234ABCD → line decodes to bytes 31 32 33 34 41 42 43 44, LSB-first 8N1. Busy lasts 320 cycles (400 cycles and trailing 0D 0A with HEX_TX_CRLF_EN).
- Edge values: 32'h00000000 → eight 8'h30. 32'hFFFFFFFF → eight 8'h46. 32'h9A000000 → first two characters are 8'h39, 8'h41.
- Back-to-back: word_valid held high with 32'hDEADBEEF then 32'h00000001 → second start bit appears exactly 2 cycles after the first word's final stop bit ends (one idle cycle). 32'h00000001 is not accepted while busy.
- Reset mid-character: assert reset during DATA of char_idx 3 → tx = 1 in the same cycle. After release, a new word 32'h0000000F transmits cleanly, starting at char_idx 0.
- Handshake: word_valid pulsed while busy → ignored. No extra transmission occurs and the original word completes intact.
